// File: rtl/text_console.sv
// Text console writer: turns a stream of CPU bytes into character/attribute
// writes into a byte-wide video RAM, with cursor control, scroll-up by one
// row and clear-screen fill.
module text_console #(
    parameter int          COLS     = 80,
    parameter int          ROWS     = 25,
    parameter logic [7:0]  DEF_ATTR = 8'h07
) (
    input  logic        clock_25,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  attr_data,
    input  logic        attr_we,
    output logic [11:0] vm_address,
    output logic [7:0]  vm_wdata,
    output logic        vm_we,
    input  logic [7:0]  vm_rdata,
    output logic [10:0] cursor
);

    localparam int          TOTAL     = COLS * ROWS;
    localparam logic [10:0] LAST_POS  = 11'(TOTAL - 1);
    localparam logic [10:0] LAST_ROW  = 11'(COLS * (ROWS - 1));
    localparam logic [10:0] COLS_C    = 11'(COLS);
    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [11:0] ROW_BYTES = 12'(2 * COLS);
    localparam logic [11:0] ADDR_LAST = 12'(2 * TOTAL - 1);
    localparam logic [11:0] FILL_ROW  = 12'(2 * COLS * (ROWS - 1));

    typedef enum logic [2:0] {IDLE, PUT_CH, PUT_AT, SCR_RD, SCR_WR, FILL} state_t;

    state_t      state_reg, state_next;
    logic [10:0] cursor_reg;
    logic [6:0]  col_reg;      // cursor mod COLS, tracked incrementally
    logic [7:0]  attr_reg;
    logic [7:0]  char_reg;
    logic [11:0] ptr_reg;      // scroll source / fill destination address
    logic        home_reg;     // fill was a clear-screen: home the cursor at the end
    logic        accept;
    logic        lf_scroll;

    assign accept    = in_valid && in_ready;
    assign lf_scroll = (cursor_reg >= LAST_ROW);
    assign cursor    = cursor_reg;

    // State register
    always_ff @(posedge clock_25) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state decode
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (in_data >= 8'h20)
                        state_next = PUT_CH;
                    else if (in_data == 8'h0A && lf_scroll)
                        state_next = SCR_RD;
                    else if (in_data == 8'h0C)
                        state_next = FILL;
                end
            end
            PUT_CH:  state_next = PUT_AT;
            PUT_AT:  state_next = (cursor_reg == LAST_POS) ? SCR_RD : IDLE;
            SCR_RD:  state_next = SCR_WR;
            SCR_WR:  state_next = (ptr_reg == ADDR_LAST) ? FILL : SCR_RD;
            FILL:    state_next = (ptr_reg == ADDR_LAST) ? IDLE : FILL;
            default: state_next = IDLE;
        endcase
    end

    // Cursor, attribute and address-pointer datapath
    always_ff @(posedge clock_25) begin
        if (reset) begin
            cursor_reg <= '0;
            col_reg    <= '0;
            attr_reg   <= DEF_ATTR;
            char_reg   <= '0;
            ptr_reg    <= '0;
            home_reg   <= 1'b0;
        end else begin
            if (attr_we)
                attr_reg <= attr_data;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        char_reg <= in_data;
                        case (in_data)
                            8'h0D: begin
                                cursor_reg <= cursor_reg - 11'(col_reg);
                                col_reg    <= '0;
                            end
                            8'h0A: begin
                                // On the last row the cursor stays put and the screen moves
                                if (lf_scroll)
                                    ptr_reg <= ROW_BYTES;
                                else
                                    cursor_reg <= cursor_reg + COLS_C;
                            end
                            8'h08: begin
                                if (col_reg != '0) begin
                                    cursor_reg <= cursor_reg - 11'd1;
                                    col_reg    <= col_reg - 7'd1;
                                end
                            end
                            8'h0C: begin
                                ptr_reg  <= '0;
                                home_reg <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                PUT_AT: begin
                    if (cursor_reg == LAST_POS) begin
                        cursor_reg <= LAST_ROW;
                        col_reg    <= '0;
                        ptr_reg    <= ROW_BYTES;
                    end else begin
                        cursor_reg <= cursor_reg + 11'd1;
                        col_reg    <= (col_reg == LAST_COL) ? 7'd0 : col_reg + 7'd1;
                    end
                end
                SCR_WR: begin
                    ptr_reg <= (ptr_reg == ADDR_LAST) ? FILL_ROW : ptr_reg + 12'd1;
                end
                FILL: begin
                    if (ptr_reg == ADDR_LAST) begin
                        if (home_reg) begin
                            cursor_reg <= '0;
                            col_reg    <= '0;
                            home_reg   <= 1'b0;
                        end
                    end else begin
                        ptr_reg <= ptr_reg + 12'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Video RAM port and handshake outputs; all forced idle while reset is held
    always_comb begin
        in_ready   = 1'b0;
        vm_address = '0;
        vm_wdata   = '0;
        vm_we      = 1'b0;
        if (!reset) begin
            case (state_reg)
                IDLE: in_ready = 1'b1;
                PUT_CH: begin
                    vm_address = {cursor_reg, 1'b0};
                    vm_wdata   = char_reg;
                    vm_we      = 1'b1;
                end
                PUT_AT: begin
                    vm_address = {cursor_reg, 1'b1};
                    vm_wdata   = attr_reg;
                    vm_we      = 1'b1;
                end
                SCR_RD: vm_address = ptr_reg;
                SCR_WR: begin
                    vm_address = ptr_reg - ROW_BYTES;
                    vm_wdata   = vm_rdata;
                    vm_we      = 1'b1;
                end
                FILL: begin
                    vm_address = ptr_reg;
                    vm_wdata   = ptr_reg[0] ? attr_reg : 8'h20;
                    vm_we      = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/text_console.md
TEXT_CONSOLE -- requirements
Module: text_console

Interface
REQ-001 Parameter COLS, default 80, characters per row.
REQ-002 Parameter ROWS, default 25, rows per screen.
REQ-003 Parameter DEF_ATTR, default 8'h07, attribute loaded at reset.
REQ-004 The clock port SHALL be clock_25, input, 1 bit; the only clock, all logic on its rising edge.
REQ-005 The reset port SHALL be reset, input, 1 bit; synchronous and active-high.
REQ-006 in_data, input, 8: byte from the CPU port.
REQ-007 in_valid, input, 1: in_data is valid.
REQ-008 in_ready, output, 1: the block accepts a byte this cycle.
REQ-009 attr_data, input, 8: new current attribute.
REQ-010 attr_we, input, 1: load attr_data into the current attribute.
REQ-011 vm_address, output, 12: video RAM byte address; char at 2*pos, attribute at 2*pos+1.
REQ-012 vm_wdata, output, 8: video RAM write data.
REQ-013 vm_we, output, 1: video RAM write strobe.
REQ-014 vm_rdata, input, 8: video RAM read data, valid exactly one cycle after vm_address is presented.
REQ-015 cursor, output, 11: cursor position, range 0..COLS*ROWS-1.

Function
REQ-016 A byte SHALL transfer only on a cycle with in_valid=1 and in_ready=1.
REQ-017 in_ready SHALL be 1 only in state IDLE and 0 in every other state and during reset.
REQ-018 States SHALL be IDLE, PUT_CH, PUT_AT, SCR_RD, SCR_WR, FILL.
REQ-019 Printable byte (>=8'h20) accepted at cycle T:
 - T+1: PUT_CH, vm_we=1, address 2*cursor, data = byte.
 - T+2: PUT_AT, vm_we=1, address 2*cursor+1, data = current attribute; cursor advances by 1 at end of T+2.
 - in_ready returns to 1 at T+3 unless a scroll starts.
REQ-020 If the advance reaches COLS*ROWS, a scroll SHALL run and cursor SHALL become COLS*(ROWS-1).
REQ-021 8'h0D (CR): cursor becomes cursor - (cursor mod COLS); returns to IDLE the next cycle; no RAM write.
REQ-022 8'h0A (LF): cursor += COLS.
 - If the result is >= COLS*ROWS: scroll, and cursor stays on the last row in the same column.
REQ-023 8'h08 (BS): cursor -= 1 only when cursor mod COLS != 0; no erase.
REQ-024 8'h0C (FF): fill the whole screen (see REQ-027), then cursor = 0.
REQ-025 Any other byte < 8'h20 SHALL be consumed with no effect; in_ready is back to 1 one cycle later.
REQ-026 Scroll SHALL step through source address s = 2*COLS .. 2*COLS*ROWS-1, two cycles per byte:
 - SCR_RD: vm_address = s, vm_we = 0.
 - SCR_WR: vm_address = s - 2*COLS, vm_wdata = vm_rdata, vm_we = 1.
 - After the last source byte, go to FILL over the last row.
REQ-027 FILL SHALL write one byte per cycle over its range: even addresses 8'h20, odd addresses the current attribute. It then returns to IDLE.
REQ-028 attr_we SHALL be honoured in any state. A write landing in the same cycle as PUT_AT or FILL does not affect that cycle's data; the new value is used from the next cycle on.
REQ-029 vm_we SHALL be 0 in IDLE and in SCR_RD.
REQ-030 Address arithmetic SHALL be 12-bit unsigned; the maximum address is 3999.
REQ-031 cursor SHALL never exceed COLS*ROWS-1, observable on any cycle.

Reset
REQ-032 While reset=1, the block SHALL hold: cursor=0, attribute=DEF_ATTR, state IDLE, vm_we=0, vm_address=0, vm_wdata=0, in_ready=0.
REQ-033 Reset asserted mid-scroll or mid-fill SHALL abort on that edge, with vm_we=0 from the next cycle.
REQ-034 Video RAM contents SHALL NOT be cleared by reset.
REQ-035 in_ready SHALL rise on the first cycle after reset is deasserted.

Verification
REQ-036 Reset, then send 8'h41 with attr 8'h1E loaded: writes (0,8'h41) at T+1 and (1,8'h1E) at T+2; cursor=1; in_ready=1 at T+3.
REQ-037 cursor=85, send 8'h0D: cursor becomes 80. Then send 8'h08: cursor stays 80 (column 0).
REQ-038 cursor=1999, send 8'h5A: writes at 3998/3999; scroll of 3840 byte copies (7680 cycles), then 160 fill writes; cursor=1920; in_ready held at 0 throughout.
REQ-039 cursor=1925, send 8'h0A: scroll; RAM[0..159] equals the old RAM[160..319]; RAM[3840]=8'h20; cursor=1925.
REQ-040 Send 8'h0C: 4000 fill writes, addr 0 = 8'h20, addr 1 = current attr; cursor=0.
REQ-041 Assert reset at the 100th cycle of a scroll: vm_we=0 the next cycle, cursor=0, and a new byte is accepted one cycle after reset falls.
